pcint_ctrl: RTL and testbench
=============================

Name: pcint_ctrl

Overview:
- Pin-change interrupt controller for one 8-pin group (PORTB/PCINT[7:0]).
- Consumes the digital-input data the GPIO port produces and holds PCMSK0, PCICR.PCIE0 and PCIFR.PCIF0.
- Raises an interrupt request to the core and feeds mask/enable back to the port's digital-input-enable override logic.
- The input-side counterpart to the port's output and override datapath.

Parameters:
- PCIFR_ADDR, 6'h1B, I/O-space address of PCIFR; bit 0 is PCIF0.
- PCICR_ADDR, 8'h68, extended-I/O (RAM-mapped) address of PCICR; bit 0 is PCIE0.
- PCMSK_ADDR, 8'h6B, extended-I/O address of PCMSK0.
- PCCAP_ADDR, 8'hEE, extended-I/O address of the capture register; only used with PCINT_CAPTURE_EN.

Ports:
- cp2  input  1  system clock; all state updates on the rising edge.
- ireset  input  1  asynchronous, active-high reset.
- IO_Addr  input  6  I/O-space address.
- iore  input  1  I/O read strobe.
- iowe  input  1  I/O write strobe.
- ramadr  input  8  extended-I/O address.
- ramre  input  1  extended-I/O read strobe.
- ramwe  input  1  extended-I/O write strobe.
- dbus_in  input  8  write data.
- dbus_out  output  8  read data; 8'h00 when out_en=0.
- out_en  output  1  high while a read hits a register in this block.
- pin_i  input  8  raw pin levels (DIB from the port); asynchronous to cp2.
- irq  output  1  interrupt request = PCIF0 & PCIE0.
- irq_ack  input  1  one-cycle vector-taken pulse from the interrupt controller.
- PCINT_o  output  8  PCMSK0 contents, to the port's DIEOE logic.
- PCIE_o  output  1  PCIE0, to the port.

Behaviour:
- Reset (ireset=1, asynchronous): PCMSK0=0, PCIE0=0, PCIF0=0, capture=0, sync stages=0, prime counter=0.
  - All outputs are 0 during reset and immediately after release.
- Synchronizer: s1<=pin_i, s2<=s1, s3<=s2 on every cp2 edge.
  - change[7:0] = (s2 ^ s3) & PCMSK0.
- Priming: a 2-bit counter increments after reset until it saturates at 3.
  - change is forced to 0 while the counter is below 3.
  - This prevents false flags from pins already high at reset release.
- Flag set: if |change, PCIF0<=1 on that edge.
  - Latency: a pin toggle meeting setup before edge k sets PCIF0 after edge k+2; irq rises in the same cycle if PCIE0=1.
- Flag set is independent of PCIE0. Enabling PCIE0 while PCIF0=1 asserts irq combinationally.
- Flag clear: an I/O write to PCIFR_ADDR with dbus_in[0]=1 clears PCIF0; writing 0 has no effect. irq_ack=1 also clears PCIF0.
- Simultaneous set and clear on the same edge: set wins, so PCIF0 stays 1 and no edge is lost.
- Register writes take effect on the edge where iowe/ramwe is high at a matching address.
  - A PCMSK0 write affects change from the next cycle.
  - PCICR and PCIFR bits [7:1] are reserved: writes are ignored, reads return 0.
- Reads are combinational.
  - out_en=1 when (iore and IO_Addr==PCIFR_ADDR) or (ramre and ramadr matches PCICR_ADDR, PCMSK_ADDR or, with the feature, PCCAP_ADDR).
  - dbus_out returns the register value.
- A toggle then untoggle within one cycle may be missed. Only level changes seen by s2/s3 count.
- Reset mid-operation: all state clears asynchronously, irq drops immediately, and priming restarts.

Optional Feature:
- Macro: PCINT_CAPTURE_EN.
- With the macro defined:
  - An 8-bit capture register accumulates change bits: cap <= cap | change.
  - It is readable at PCCAP_ADDR.
  - A read (ramre hit) clears it on the next edge, except that bits changing on that same edge are kept (OR wins).
  - It is cleared by reset.
- Without the macro: no register is present, PCCAP_ADDR does not decode, and out_en stays 0 for that address.

Decomposition:
- Shared package pcint_pkg holds:
  - the default address constants;
  - the PCIF0/PCIE0 bit index constants;
  - a prime-counter width constant.
- Natural sub-module: pcint_sync (8-bit 3-stage synchronizer with edge output).
  - It is reused by the future PCINT1/PCINT2 groups for ports C and D.

Test Plan:
- Reset with pin_i=8'hFF, PCMSK0=8'hFF written right after reset -> PCIF0 stays 0 and irq=0 for 10 cycles.
- PCMSK0=8'h04, PCIE0=1, toggle pin_i[2] 0->1 before edge k -> PCIF0=1 and irq=1 after edge k+2; a toggle on pin_i[3] alone sets nothing.
- PCIF0=1, I/O write 8'h01 to 6'h1B -> PCIF0=0, irq=0; a write of 8'h00 leaves the flag set.
- irq_ack pulse on the same edge as a new masked change on pin_i[0] -> PCIF0 remains 1 (set wins).
- PCIE0=0, masked toggle -> PCIF0=1 and irq=0; then write PCICR=8'h01 -> irq=1 next cycle; a PCICR read returns 8'h01 with out_en=1.
- With PCINT_CAPTURE_EN: toggle pins 1 and 6 with mask 8'hFF -> PCCAP reads 8'h42, then reads 8'h00 on the following access.

Source files
------------

// File: rtl/pcint_pkg.sv
// Shared constants for the pin-change interrupt groups (PCINT0/1/2).
// The optional capture register is enabled by defining PCINT_CAPTURE_EN.
package pcint_pkg;

    localparam logic [5:0] PCIFR_ADDR_DEF = 6'h1B;
    localparam logic [7:0] PCICR_ADDR_DEF = 8'h68;
    localparam logic [7:0] PCMSK_ADDR_DEF = 8'h6B;
    localparam logic [7:0] PCCAP_ADDR_DEF = 8'hEE;

    localparam int unsigned PCIF0_BIT = 0;
    localparam int unsigned PCIE0_BIT = 0;

    // Edges after reset before pin changes are trusted.
    localparam int unsigned         PRIME_W    = 2;
    localparam logic [PRIME_W-1:0]  PRIME_DONE = '1;

endpackage

// File: rtl/pcint_sync.sv
// Three-stage pin synchronizer; reports bits whose synchronized level moved
// between the last two stages.
module pcint_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] toggled
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign toggled = s2 ^ s3;

endmodule

// File: rtl/pcint_ctrl.sv
// PCINT0 pin-change interrupt controller: PCMSK0, PCICR.PCIE0, PCIFR.PCIF0.
// Define PCINT_CAPTURE_EN to add the read-to-clear change capture register.
module pcint_ctrl
    import pcint_pkg::*;
#(
    parameter logic [5:0] PCIFR_ADDR = PCIFR_ADDR_DEF,
    parameter logic [7:0] PCICR_ADDR = PCICR_ADDR_DEF,
    parameter logic [7:0] PCMSK_ADDR = PCMSK_ADDR_DEF,
    parameter logic [7:0] PCCAP_ADDR = PCCAP_ADDR_DEF
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] IO_Addr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       out_en,
    input  logic [7:0] pin_i,
    output logic       irq,
    input  logic       irq_ack,
    output logic [7:0] PCINT_o,
    output logic       PCIE_o
);

`ifdef PCINT_CAPTURE_EN
    localparam bit CAP_PRESENT = 1'b1;
`else
    localparam bit CAP_PRESENT = 1'b0;
`endif

    logic [7:0]         mask;
    logic               pcie;
    logic               pcif;
    logic [7:0]         cap;
    logic [PRIME_W-1:0] prime;
    logic [7:0]         toggled;
    logic [7:0]         change;

    logic pcifr_wr, pcicr_wr, pcmsk_wr;
    logic pcifr_rd, pcicr_rd, pcmsk_rd, pccap_rd;
    logic flag_clr;

    pcint_sync #(.WIDTH(8)) u_sync (
        .clk     (cp2),
        .rst     (ireset),
        .pin     (pin_i),
        .toggled (toggled)
    );

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset)
            prime <= '0;
        else if (prime != PRIME_DONE)
            prime <= prime + 1'b1;
    end

    assign change = (prime == PRIME_DONE) ? (toggled & mask) : '0;

    assign pcifr_wr = iowe  && (IO_Addr == PCIFR_ADDR);
    assign pcicr_wr = ramwe && (ramadr  == PCICR_ADDR);
    assign pcmsk_wr = ramwe && (ramadr  == PCMSK_ADDR);
    assign pcifr_rd = iore  && (IO_Addr == PCIFR_ADDR);
    assign pcicr_rd = ramre && (ramadr  == PCICR_ADDR);
    assign pcmsk_rd = ramre && (ramadr  == PCMSK_ADDR);
    assign pccap_rd = CAP_PRESENT && ramre && (ramadr == PCCAP_ADDR);

    assign flag_clr = (pcifr_wr && dbus_in[PCIF0_BIT]) || irq_ack;

    // A new change outranks any clear on the same edge so no edge is lost.
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset)
            pcif <= 1'b0;
        else if (|change)
            pcif <= 1'b1;
        else if (flag_clr)
            pcif <= 1'b0;
    end

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            pcie <= 1'b0;
            mask <= '0;
        end else begin
            if (pcicr_wr)
                pcie <= dbus_in[PCIE0_BIT];
            if (pcmsk_wr)
                mask <= dbus_in;
        end
    end

`ifdef PCINT_CAPTURE_EN
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset)
            cap <= '0;
        else
            cap <= (pccap_rd ? '0 : cap) | change;
    end
`else
    assign cap = '0;
`endif

    always_comb begin
        dbus_out = '0;
        out_en   = 1'b0;
        if (pcifr_rd) begin
            out_en              = 1'b1;
            dbus_out[PCIF0_BIT] = pcif;
        end else if (pcicr_rd) begin
            out_en              = 1'b1;
            dbus_out[PCIE0_BIT] = pcie;
        end else if (pcmsk_rd) begin
            out_en   = 1'b1;
            dbus_out = mask;
        end else if (pccap_rd) begin
            out_en   = 1'b1;
            dbus_out = cap;
        end
    end

    assign irq     = pcif & pcie;
    assign PCINT_o = mask;
    assign PCIE_o  = pcie;

endmodule

// File: tb/tb_pcint_ctrl.sv
// Self-checking bench for pcint_ctrl; exercises PCINT_CAPTURE_EN paths when defined.
module tb_pcint_ctrl;

    logic       cp2 = 1'b0;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore, iowe;
    logic [7:0] ramadr;
    logic       ramre, ramwe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [7:0] pin_i;
    logic       irq;
    logic       irq_ack;
    logic [7:0] PCINT_o;
    logic       PCIE_o;

    int tests = 0;
    int fails = 0;

    pcint_ctrl dut (
        .cp2      (cp2),
        .ireset   (ireset),
        .IO_Addr  (IO_Addr),
        .iore     (iore),
        .iowe     (iowe),
        .ramadr   (ramadr),
        .ramre    (ramre),
        .ramwe    (ramwe),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .out_en   (out_en),
        .pin_i    (pin_i),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .PCINT_o  (PCINT_o),
        .PCIE_o   (PCIE_o)
    );

    always #5 cp2 = ~cp2;

    // Reference model: pin samples per edge (newest first) plus register values.
    logic [7:0] hist[$];
    logic [7:0] m_mask;
    logic       m_pcie;
    logic       m_pcif;
    logic [7:0] m_cap;
    int         m_edges;

    task automatic model_reset();
        hist    = '{8'h00, 8'h00, 8'h00};
        m_mask  = 8'h00;
        m_pcie  = 1'b0;
        m_pcif  = 1'b0;
        m_cap   = 8'h00;
        m_edges = 0;
    endtask

    task automatic idle_bus();
        iore = 1'b0; iowe = 1'b0; ramre = 1'b0; ramwe = 1'b0;
        irq_ack = 1'b0; IO_Addr = 6'h00; ramadr = 8'h00; dbus_in = 8'h00;
    endtask

    // One cp2 edge: a pin seen at edge k counts at edge k+2, once 3 edges have passed since reset.
    task automatic tick();
        logic [7:0] chg;
        logic       clr;
        logic [7:0] pin_now;
        chg     = (m_edges >= 3) ? ((hist[1] ^ hist[2]) & m_mask) : 8'h00;
        clr     = irq_ack || (iowe && IO_Addr == 6'h1B && dbus_in[0]);
        pin_now = pin_i;
        @(posedge cp2);
        if (chg != 8'h00)
            m_pcif = 1'b1;
        else if (clr)
            m_pcif = 1'b0;
        if (ramwe && ramadr == 8'h68) m_pcie = dbus_in[0];
        if (ramwe && ramadr == 8'h6B) m_mask = dbus_in;
`ifdef PCINT_CAPTURE_EN
        m_cap = ((ramre && ramadr == 8'hEE) ? 8'h00 : m_cap) | chg;
`endif
        hist.push_front(pin_now);
        void'(hist.pop_back());
        m_edges++;
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        IO_Addr = a; dbus_in = d; iowe = 1'b1;
        tick();
        iowe = 1'b0;
    endtask

    task automatic ram_write(input logic [7:0] a, input logic [7:0] d);
        ramadr = a; dbus_in = d; ramwe = 1'b1;
        tick();
        ramwe = 1'b0;
    endtask

    function automatic logic [8:0] exp_read();
        if (iore && IO_Addr == 6'h1B) return {1'b1, 7'h00, m_pcif};
        if (ramre) begin
            if (ramadr == 8'h68) return {1'b1, 7'h00, m_pcie};
            if (ramadr == 8'h6B) return {1'b1, m_mask};
`ifdef PCINT_CAPTURE_EN
            if (ramadr == 8'hEE) return {1'b1, m_cap};
`endif
        end
        return 9'h000;
    endfunction

    task automatic test_reset();
        idle_bus();
        pin_i  = 8'hFF;
        ireset = 1'b1;
        repeat (2) @(posedge cp2);
        #1;
        model_reset();
        tests++;
        if ({irq, PCIE_o, PCINT_o, out_en, dbus_out} !== 19'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", {irq, PCIE_o, PCINT_o, out_en, dbus_out});
        end
        ireset = 1'b0;
        #1;
        tests++;
        if ({irq, PCIE_o, PCINT_o, out_en, dbus_out} !== 19'h0) begin
            fails++;
            $display("FAIL release_outputs: got %h want 0", {irq, PCIE_o, PCINT_o, out_en, dbus_out});
        end
        ram_write(8'h6B, 8'hFF);
        tests++;
        if (PCINT_o !== 8'hFF) begin
            fails++;
            $display("FAIL mask_write: got %h want ff", PCINT_o);
        end
        iore = 1'b1; IO_Addr = 6'h1B;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (irq !== 1'b0 || dbus_out !== 8'h00 || out_en !== 1'b1) begin
                fails++;
                $display("FAIL prime_no_flag[%0d]: got irq=%b pcifr=%h oe=%b want 0/00/1", i, irq, dbus_out, out_en);
            end
        end
        idle_bus();
    endtask

    task automatic test_masked_toggle();
        ram_write(8'h6B, 8'h04);
        ram_write(8'h68, 8'h01);
        pin_i = 8'h00;
        settle(5);
        io_write(6'h1B, 8'h01);
        settle(2);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL toggle_baseline: got irq=%b want 0", irq);
        end
        pin_i = 8'h04;
        tick();
        tick();
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL toggle_early: got irq=%b want 0 after edge k+1", irq);
        end
        tick();
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL toggle_latency: got irq=%b want 1 after edge k+2", irq);
        end
        io_write(6'h1B, 8'h01);
        pin_i = pin_i ^ 8'h08;
        settle(5);
        iore = 1'b1; IO_Addr = 6'h1B;
        #1;
        tests++;
        if (irq !== 1'b0 || dbus_out !== 8'h00) begin
            fails++;
            $display("FAIL unmasked_pin: got irq=%b pcifr=%h want 0/00", irq, dbus_out);
        end
        idle_bus();
    endtask

    task automatic test_flag_clear();
        pin_i = pin_i ^ 8'h04;
        settle(4);
        iore = 1'b1; IO_Addr = 6'h1B;
        #1;
        tests++;
        if (dbus_out !== 8'h01 || out_en !== 1'b1) begin
            fails++;
            $display("FAIL pcifr_read_set: got %h oe=%b want 01/1", dbus_out, out_en);
        end
        iore = 1'b0;
        io_write(6'h1B, 8'h00);
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL write0_no_clear: got irq=%b want 1", irq);
        end
        io_write(6'h1B, 8'hFE);
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL write_fe_no_clear: got irq=%b want 1", irq);
        end
        io_write(6'h1B, 8'h01);
        iore = 1'b1; IO_Addr = 6'h1B;
        #1;
        tests++;
        if (irq !== 1'b0 || dbus_out !== 8'h00) begin
            fails++;
            $display("FAIL write1_clear: got irq=%b pcifr=%h want 0/00", irq, dbus_out);
        end
        idle_bus();
    endtask

    task automatic test_set_wins();
        ram_write(8'h6B, 8'h01);
        pin_i = pin_i ^ 8'h01;
        tick();
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL set_wins_over_ack: got irq=%b want 1", irq);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL ack_clears: got irq=%b want 0", irq);
        end
    endtask

    task automatic test_late_enable();
        ram_write(8'h68, 8'h00);
        pin_i = pin_i ^ 8'h01;
        settle(4);
        iore = 1'b1; IO_Addr = 6'h1B;
        #1;
        tests++;
        if (irq !== 1'b0 || dbus_out !== 8'h01) begin
            fails++;
            $display("FAIL flag_without_enable: got irq=%b pcifr=%h want 0/01", irq, dbus_out);
        end
        iore = 1'b0;
        ram_write(8'h68, 8'h01);
        tests++;
        if (irq !== 1'b1 || PCIE_o !== 1'b1) begin
            fails++;
            $display("FAIL late_enable_irq: got irq=%b pcie=%b want 1/1", irq, PCIE_o);
        end
        ramre = 1'b1; ramadr = 8'h68;
        #1;
        tests++;
        if (dbus_out !== 8'h01 || out_en !== 1'b1) begin
            fails++;
            $display("FAIL pcicr_read: got %h oe=%b want 01/1", dbus_out, out_en);
        end
        ramre = 1'b0;
        ram_write(8'h68, 8'hFE);
        ramre = 1'b1; ramadr = 8'h68;
        #1;
        tests++;
        if (dbus_out !== 8'h00 || irq !== 1'b0 || PCIE_o !== 1'b0) begin
            fails++;
            $display("FAIL pcicr_reserved: got rd=%h irq=%b pcie=%b want 00/0/0", dbus_out, irq, PCIE_o);
        end
        ramre = 1'b0;
        ram_write(8'h68, 8'h01);
        ramre = 1'b1; ramadr = 8'h6B;
        #1;
        tests++;
        if (dbus_out !== 8'h01 || out_en !== 1'b1) begin
            fails++;
            $display("FAIL pcmsk_read: got %h oe=%b want 01/1", dbus_out, out_en);
        end
        ramadr = 8'h69;
        #1;
        tests++;
        if (dbus_out !== 8'h00 || out_en !== 1'b0) begin
            fails++;
            $display("FAIL unmapped_read: got %h oe=%b want 00/0", dbus_out, out_en);
        end
        idle_bus();
        iore = 1'b1; IO_Addr = 6'h1C;
        #1;
        tests++;
        if (dbus_out !== 8'h00 || out_en !== 1'b0) begin
            fails++;
            $display("FAIL io_unmapped_read: got %h oe=%b want 00/0", dbus_out, out_en);
        end
        idle_bus();
    endtask

    task automatic test_capture();
`ifdef PCINT_CAPTURE_EN
        ram_write(8'h6B, 8'hFF);
        settle(4);
        ramre = 1'b1; ramadr = 8'hEE;
        tick();
        ramre = 1'b0;
        pin_i = pin_i ^ 8'h42;
        settle(4);
        ramre = 1'b1; ramadr = 8'hEE;
        #1;
        tests++;
        if (dbus_out !== 8'h42 || out_en !== 1'b1) begin
            fails++;
            $display("FAIL capture_read: got %h oe=%b want 42/1", dbus_out, out_en);
        end
        tick();
        tests++;
        if (dbus_out !== 8'h00) begin
            fails++;
            $display("FAIL capture_clear: got %h want 00", dbus_out);
        end
        idle_bus();
        io_write(6'h1B, 8'h01);
`else
        ramre = 1'b1; ramadr = 8'hEE;
        #1;
        tests++;
        if (dbus_out !== 8'h00 || out_en !== 1'b0) begin
            fails++;
            $display("FAIL pccap_absent: got %h oe=%b want 00/0", dbus_out, out_en);
        end
        idle_bus();
`endif
    endtask

    task automatic test_random();
        logic [8:0] er;
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            idle_bus();
            if ($urandom_range(0, 2) == 0) pin_i = pin_i ^ 8'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0: begin iowe = 1'b1; IO_Addr = 6'h1B; dbus_in = 8'($urandom); end
                1: begin ramwe = 1'b1; ramadr = 8'h68; dbus_in = 8'($urandom); end
                2: begin ramwe = 1'b1; ramadr = 8'h6B; dbus_in = 8'($urandom); end
                3: irq_ack = 1'b1;
                4: begin ramwe = 1'b1; ramadr = 8'($urandom); dbus_in = 8'($urandom); end
                default: ;
            endcase
            r = $urandom_range(0, 5);
            case (r)
                0: begin iore = 1'b1; IO_Addr = 6'h1B; end
                1: begin iore = 1'b1; IO_Addr = 6'($urandom); end
                2: begin ramre = 1'b1; ramadr = 8'h68; end
                3: begin ramre = 1'b1; ramadr = 8'h6B; end
                4: begin ramre = 1'b1; ramadr = ($urandom_range(0, 1) == 0) ? 8'hEE : 8'($urandom); end
                default: ;
            endcase
            #1;
            er = exp_read();
            tests++;
            if ({out_en, dbus_out} !== er) begin
                fails++;
                $display("FAIL rand_read[%0d]: got oe=%b d=%h want oe=%b d=%h", i, out_en, dbus_out, er[8], er[7:0]);
            end
            tick();
            tests++;
            if (irq !== (m_pcif & m_pcie) || PCINT_o !== m_mask || PCIE_o !== m_pcie) begin
                fails++;
                $display("FAIL rand_state[%0d]: got irq=%b msk=%h pcie=%b want irq=%b msk=%h pcie=%b",
                         i, irq, PCINT_o, PCIE_o, m_pcif & m_pcie, m_mask, m_pcie);
            end
            if (i == 200) begin
                idle_bus();
                ireset = 1'b1;
                #1;
                tests++;
                if (irq !== 1'b0 || PCINT_o !== 8'h00 || PCIE_o !== 1'b0) begin
                    fails++;
                    $display("FAIL async_reset: got irq=%b msk=%h pcie=%b want 0/00/0", irq, PCINT_o, PCIE_o);
                end
                @(posedge cp2);
                #1;
                model_reset();
                ireset = 1'b0;
            end
        end
        idle_bus();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_masked_toggle();
        test_flag_clear();
        test_set_wins();
        test_late_enable();
        test_capture();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
